// File: rtl/bp_nonsynth_io_responder.sv
// Single-beat uncached IO endpoint with dword backing memory.
// Option: BP_NONSYNTH_IO_RESPONDER_RANDOM_LATENCY_EN adds LFSR latency jitter.
module bp_nonsynth_io_responder
  #(parameter int paddr_width_p = 40
  , parameter int did_width_p = 4
  , parameter int lce_id_width_p = 4
  , parameter int io_data_width_p = 64
  , parameter int mem_els_p = 4096
  , parameter logic [63:0] base_addr_p = 64'h8000_0000
  , parameter logic [63:0] finish_addr_p = 64'h0010_2000
  , parameter int resp_latency_p = 2
  , localparam int mem_header_width_lp =
      did_width_p + lce_id_width_p + 3 + paddr_width_p + 4
  )
  (input  logic clk_i
  , input  logic reset_n_i
  , input  logic [mem_header_width_lp-1:0] io_cmd_header_i
  , input  logic [63:0] io_cmd_data_i
  , input  logic io_cmd_v_i
  , output logic io_cmd_yumi_o
  , input  logic io_cmd_last_i
  , output logic [mem_header_width_lp-1:0] io_resp_header_o
  , output logic [63:0] io_resp_data_o
  , output logic io_resp_v_o
  , input  logic io_resp_ready_and_i
  , output logic io_resp_last_o
  , output logic done_o
  , output logic error_o
  );

  if (io_data_width_p != 64) begin : g_width_chk
    $fatal(1, "io_data_width_p must be 64");
  end
  if ((mem_els_p & (mem_els_p - 1)) != 0) begin : g_els_chk
    $fatal(1, "mem_els_p must be a power of two");
  end

  localparam int idx_w_lp = $clog2(mem_els_p);
  localparam int cnt_w_lp = $clog2(resp_latency_p + 4);
  localparam logic [paddr_width_p-1:0] base_lp =
    paddr_width_p'(base_addr_p);
  localparam logic [paddr_width_p-1:0] finish_lp =
    paddr_width_p'(finish_addr_p);

  typedef struct packed {
    logic [did_width_p-1:0] did;
    logic [lce_id_width_p-1:0] lce_id;
  } payload_s;

  typedef struct packed {
    payload_s payload;
    logic [2:0] size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0] msg_type;
  } hdr_s;

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  // Release is synchronized, assertion stays asynchronous
  logic [1:0] rst_sync_r;
  logic rst_n;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) rst_sync_r <= '0;
    else rst_sync_r <= {rst_sync_r[0], 1'b1};
  assign rst_n = rst_sync_r[1];

  state_e state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r, lat;
  logic [mem_header_width_lp-1:0] hdr_r;
  logic [63:0] data_r;
  logic done_r, error_r, accept;

  hdr_s cmd;
  assign cmd = io_cmd_header_i;

  logic is_rd, is_wr, hit_fin, in_rng, misal, bad;
  logic [paddr_width_p-1:0] off;
  logic [2:0] boff;
  logic [idx_w_lp-1:0] idx;
  logic [7:0] bmask;
  logic [63:0] wmask, rd_dw, shifted, rd_data;
  logic [63:0] mem_r [mem_els_p];

  assign is_rd = cmd.msg_type == 4'b0000;
  assign is_wr = cmd.msg_type == 4'b0001;
  assign hit_fin = cmd.addr == finish_lp;
  assign off = cmd.addr - base_lp;
  assign boff = off[2:0];
  assign idx = off[3+:idx_w_lp];
  assign in_rng = (cmd.addr >= base_lp)
    && (off[paddr_width_p-1:3+idx_w_lp] == '0);

  always_comb begin
    misal = 1'b1;
    bmask = 8'h00;
    unique case (cmd.size)
      3'd0: begin misal = 1'b0; bmask = 8'h01; end
      3'd1: begin misal = boff[0]; bmask = 8'h03; end
      3'd2: begin misal = |boff[1:0]; bmask = 8'h0f; end
      3'd3: begin misal = |boff; bmask = 8'hff; end
      default: ;
    endcase
    bmask = bmask << boff;
  end

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 8; i++)
      wmask[8*i+:8] = {8{bmask[i]}};
  end

  assign rd_dw = mem_r[idx];
  assign shifted = rd_dw >> {boff, 3'b000};

  always_comb begin
    rd_data = shifted;
    unique case (cmd.size)
      3'd0: rd_data = {8{shifted[7:0]}};
      3'd1: rd_data = {4{shifted[15:0]}};
      3'd2: rd_data = {2{shifted[31:0]}};
      default: ;
    endcase
  end

  // The finish address may lie outside the backing store
  assign bad = !(is_rd || is_wr) || !io_cmd_last_i || misal
    || (!(is_wr && hit_fin) && !in_rng);

`ifdef BP_NONSYNTH_IO_RESPONDER_RANDOM_LATENCY_EN
  logic [7:0] lfsr_r;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) lfsr_r <= 8'h5a;
    else if (accept)
      lfsr_r <= {lfsr_r[6:0],
        lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  assign lat = cnt_w_lp'(resp_latency_p)
    + cnt_w_lp'(lfsr_r[1:0]);
`else
  assign lat = cnt_w_lp'(resp_latency_p);
`endif

  always_ff @(posedge clk_i)
    if (accept && is_wr && !bad && !hit_fin)
      mem_r[idx] <= (rd_dw & ~wmask) | (io_cmd_data_i & wmask);

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state_r <= e_ready;
    else state_r <= state_n;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_ready: if (accept)
        state_n = (lat == '0) ? e_resp : e_wait;
      e_wait: if (cnt_r == cnt_w_lp'(1)) state_n = e_resp;
      e_resp: if (io_resp_ready_and_i) state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  always_comb begin
    io_cmd_yumi_o = rst_n && (state_r == e_ready) && io_cmd_v_i;
    io_resp_v_o = state_r == e_resp;
    io_resp_last_o = state_r == e_resp;
  end

  assign accept = io_cmd_yumi_o;

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      cnt_r <= '0;
      hdr_r <= '0;
      data_r <= '0;
      done_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      if (accept) begin
        cnt_r <= lat;
        hdr_r <= io_cmd_header_i;
        data_r <= (is_rd && !bad) ? rd_data : '0;
        if (bad) error_r <= 1'b1;
        if (is_wr && hit_fin && !bad) done_r <= 1'b1;
      end else if (state_r == e_wait) begin
        cnt_r <= cnt_r - cnt_w_lp'(1);
      end
    end

  assign io_resp_header_o = hdr_r;
  assign io_resp_data_o = data_r;
  assign done_o = done_r;
  assign error_o = error_r;

endmodule

// File: tb/tb_bp_nonsynth_io_responder.sv
// Scoreboard bench for bp_nonsynth_io_responder.
// Second instance runs with zero response latency.
module tb_bp_nonsynth_io_responder;

  localparam logic [39:0] BASE = 40'h80000000;
  localparam logic [39:0] FIN = 40'h00102000;
  localparam logic [3:0] RD = 4'h0;
  localparam logic [3:0] WR = 4'h1;

  logic clk, reset_n;
  logic [54:0] cmd_hdr, resp_hdr;
  logic [63:0] cmd_data, resp_data;
  logic cmd_v, yumi, cmd_last;
  logic resp_v, ready, resp_last, done, error;

  logic [54:0] hdr0, rhdr0;
  logic [63:0] data0, rdata0;
  logic v0, yumi0, last0, rv0, rlast0, done0, err0;

  int checks = 0;
  int errors = 0;
  logic [118:0] sb[$];

  bp_nonsynth_io_responder #(.resp_latency_p(2)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .io_cmd_header_i(cmd_hdr), .io_cmd_data_i(cmd_data),
    .io_cmd_v_i(cmd_v), .io_cmd_yumi_o(yumi),
    .io_cmd_last_i(cmd_last),
    .io_resp_header_o(resp_hdr), .io_resp_data_o(resp_data),
    .io_resp_v_o(resp_v), .io_resp_ready_and_i(ready),
    .io_resp_last_o(resp_last),
    .done_o(done), .error_o(error));

  bp_nonsynth_io_responder #(.resp_latency_p(0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n),
    .io_cmd_header_i(hdr0), .io_cmd_data_i(data0),
    .io_cmd_v_i(v0), .io_cmd_yumi_o(yumi0),
    .io_cmd_last_i(last0),
    .io_resp_header_o(rhdr0), .io_resp_data_o(rdata0),
    .io_resp_v_o(rv0), .io_resp_ready_and_i(1'b1),
    .io_resp_last_o(rlast0),
    .done_o(done0), .error_o(err0));

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] mk(input logic [3:0] mt,
                                     input logic [39:0] a,
                                     input logic [2:0] sz);
    return {4'h2, 4'h5, sz, a, mt};
  endfunction

  always @(negedge clk)
    if (resp_v && ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
      else begin
        logic [118:0] e;
        e = sb.pop_front();
        chk("resp_hdr", 64'(resp_hdr), 64'(e[54:0]));
        chk("resp_data", resp_data, e[118:55]);
        chk("resp_last", 64'(resp_last), 64'd1);
      end
    end

  task automatic send(input logic [54:0] h, input logic [63:0] d,
                      input logic [63:0] ed, input int hold);
    int n, c;
    @(negedge clk);
    cmd_hdr = h; cmd_data = d; cmd_v = 1'b1; cmd_last = 1'b1;
    sb.push_back({ed, h});
    #1;
    n = 0;
    while (!yumi && n < 20) begin @(negedge clk); #1; n++; end
    chk("yumi_wait", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    cmd_v = 1'b0;
    if (hold > 0) ready = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!resp_v && c < 20);
    chk("latency", 64'(c), 64'd3);
    if (hold > 0) begin
      repeat (hold - 1) begin
        @(negedge clk);
        chk("hold_v", 64'(resp_v), 64'd1);
        chk("hold_hdr", 64'(resp_hdr), 64'(h));
        chk("hold_data", resp_data, ed);
      end
      @(posedge clk); #1 ready = 1'b1;
      @(negedge clk);
      chk("hs_v", 64'(resp_v), 64'd1);
    end
    @(posedge clk); #1;
    chk("post_v", 64'(resp_v), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    clk = 1'b0; reset_n = 1'b0; ready = 1'b1;
    cmd_v = 1'b1; cmd_last = 1'b1; cmd_data = '0;
    cmd_hdr = mk(RD, BASE, 3'd3);
    v0 = 1'b0; last0 = 1'b1; data0 = '0; hdr0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_yumi", 64'(yumi), 64'd0);
    chk("rst_v", 64'(resp_v), 64'd0);
    chk("rst_last", 64'(resp_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    chk("rst_hdr", 64'(resp_hdr), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    cmd_v = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);

    send(mk(WR, BASE + 40'h10, 3'd3), 64'h1122334455667788, 64'd0, 0);
    send(mk(RD, BASE + 40'h10, 3'd3), 64'd0, 64'h1122334455667788, 0);
    chk("err_clean", 64'(error), 64'd0);

    send(mk(WR, BASE + 40'h13, 3'd0), {8{8'hAB}}, 64'd0, 0);
    send(mk(RD, BASE + 40'h10, 3'd3), 64'd0, 64'h11223344AB667788, 0);
    send(mk(RD, BASE + 40'h12, 3'd1), 64'd0, 64'hAB66AB66AB66AB66, 0);

    send(mk(RD, BASE + 40'h10, 3'd3), 64'd0, 64'h11223344AB667788, 5);

    @(negedge clk);
    hdr0 = mk(WR, BASE, 3'd3); data0 = 64'h5555; v0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("b2b_yumi", 64'(yumi0), 64'(i % 2 == 0));
      chk("b2b_v", 64'(rv0), 64'(i % 2 == 1));
      @(negedge clk);
    end
    v0 = 1'b0;

    send(mk(WR, BASE, 3'd3), 64'h0123456789ABCDEF, 64'd0, 0);
    chk("err_pre", 64'(error), 64'd0);
    send(mk(WR, BASE + 40'h2, 3'd2), '1, 64'd0, 0);
    chk("err_misal", 64'(error), 64'd1);
    send(mk(RD, BASE, 3'd3), 64'd0, 64'h0123456789ABCDEF, 0);
    send(mk(RD, BASE + 40'h8000, 3'd3), 64'd0, 64'd0, 0);
    chk("err_sticky", 64'(error), 64'd1);

    chk("done_pre", 64'(done), 64'd0);
    send(mk(WR, FIN, 3'd3), 64'h1, 64'd0, 0);
    chk("done_set", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    chk("done_hold", 64'(done), 64'd1);

    @(negedge clk);
    cmd_hdr = mk(RD, BASE, 3'd3); cmd_v = 1'b1;
    @(posedge clk); #1 cmd_v = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("arst_v", 64'(resp_v), 64'd0);
    chk("arst_yumi", 64'(yumi), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(error), 64'd0);
    chk("arst_hdr", 64'(resp_hdr), 64'd0);
    chk("arst_data", resp_data, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_v) seen++;
    end
    chk("no_resp", 64'(seen), 64'd0);
    chk("done_cleared", 64'(done), 64'd0);
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
